mem_arb_n: RTL and testbench

MEM_ARB_N -- requirements
Module: mem_arb_n

---
 rtl/mem_arb_n.sv | 182 ++++++++++++++++++
 tb/tb_mem_arb_n.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_n.sv
// Round-robin arbiter that funnels NUM_CH requester channels onto one memory port, one transaction at a time.
// Optional read watchdog enabled by defining MEM_ARB_RD_TIMEOUT_EN.
module mem_arb_n #(
   parameter int NUM_CH     = 4,
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 16,
   parameter int RD_TIMEOUT = 1024
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_address,
   input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] ch_byteenable,
   input  logic [NUM_CH-1:0]                ch_read,
   input  logic [NUM_CH-1:0]                ch_write,
   input  logic [NUM_CH*DATA_WIDTH-1:0]     ch_writedata,
   output logic [DATA_WIDTH-1:0]            ch_readdata,
   output logic [NUM_CH-1:0]                ch_readdataready,
   output logic [NUM_CH-1:0]                ch_waitrequest,
   output logic [ADDR_WIDTH-1:0]            mem_address,
   output logic [DATA_WIDTH/8-1:0]          mem_byteenable,
   output logic                             mem_read,
   output logic                             mem_write,
   output logic [DATA_WIDTH-1:0]            mem_writedata,
   input  logic [DATA_WIDTH-1:0]            mem_readdata,
   input  logic                             mem_readdataready,
   input  logic                             mem_waitrequest,
   output logic                             timeout_err
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int GW       = $clog2(NUM_CH);
   localparam logic [GW:0]   NUM_CH_W  = NUM_CH[GW:0];
   localparam logic [GW-1:0] LAST_INIT = GW'(NUM_CH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_grant;
   logic [GW-1:0]   r_last_grant;
   logic [NUM_CH-1:0] w_req;
   logic            w_found;
   logic [GW-1:0]   w_next;
   logic [GW:0]     w_sum;
   logic [GW-1:0]   w_idx;
   logic            w_g_rd;
   logic            w_g_wr;
   logic            w_timeout;

   // Round-robin search starting one past the last accepted channel.
   always_comb begin
      w_req   = ch_read | ch_write;
      w_found = 1'b0;
      w_next  = r_last_grant;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_sum = {1'b0, r_last_grant} + k[GW:0];
         if (w_sum >= NUM_CH_W) begin
            w_sum = w_sum - NUM_CH_W;
         end else begin
            w_sum = w_sum;
         end
         w_idx = w_sum[GW-1:0];
         if (!w_found && w_req[w_idx]) begin
            w_found = 1'b1;
            w_next  = w_idx;
         end else begin
            w_found = w_found;
         end
      end
   end

   // A read takes priority when the granted channel raises both strobes.
   always_comb begin
      w_g_rd = ch_read[r_grant];
      w_g_wr = ch_write[r_grant] & ~ch_read[r_grant];
   end

`ifdef MEM_ARB_RD_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        r_timeout_err;

   assign w_timeout   = (r_state == WAIT_RD) && !mem_readdataready &&
                        (r_cnt == 16'(RD_TIMEOUT - 1));
   assign timeout_err = r_timeout_err;

   // Watchdog counts wait cycles of the current read; the error flag is sticky.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt         <= 16'd0;
         r_timeout_err <= 1'b0;
      end else begin
         if ((r_state == WAIT_RD) && !mem_readdataready && !w_timeout) begin
            r_cnt <= r_cnt + 16'd1;
         end else begin
            r_cnt <= 16'd0;
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end else begin
            r_timeout_err <= r_timeout_err;
         end
      end
   end
`else
   assign w_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Memory request and channel handshakes follow the granted channel.
   always_comb begin
      mem_address      = ch_address[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
      mem_byteenable   = ch_byteenable[r_grant*BE_WIDTH +: BE_WIDTH];
      mem_writedata    = ch_writedata[r_grant*DATA_WIDTH +: DATA_WIDTH];
      mem_read         = (r_state == ISSUE) & w_g_rd;
      mem_write        = (r_state == ISSUE) & w_g_wr;
      ch_waitrequest   = {NUM_CH{1'b1}};
      ch_readdataready = {NUM_CH{1'b0}};
      ch_readdata      = mem_readdata;
      case (r_state)
         ISSUE: begin
            ch_waitrequest[r_grant] = mem_waitrequest;
         end
         WAIT_RD: begin
            ch_readdataready[r_grant] = mem_readdataready | w_timeout;
            if (w_timeout) begin
               ch_readdata = {DATA_WIDTH{1'b1}};
            end else begin
               ch_readdata = mem_readdata;
            end
         end
         default: begin
            ch_waitrequest = {NUM_CH{1'b1}};
         end
      endcase
   end

   // Transaction FSM; last_grant only advances once memory accepts.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_last_grant <= LAST_INIT;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant <= w_next;
                  r_state <= ISSUE;
               end else begin
                  r_state <= IDLE;
               end
            end
            ISSUE: begin
               if (!w_g_rd && !w_g_wr) begin
                  r_state <= IDLE;
               end else if (!mem_waitrequest) begin
                  r_last_grant <= r_grant;
                  r_state      <= w_g_rd ? WAIT_RD : IDLE;
               end else begin
                  r_state <= ISSUE;
               end
            end
            WAIT_RD: begin
               if (mem_readdataready || w_timeout) begin
                  r_state <= IDLE;
               end else begin
                  r_state <= WAIT_RD;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arb_n.sv
// Directed testbench for mem_arb_n (NUM_CH=4): vector table plus hand-written multi-cycle sequences.
module tb_mem_arb_n;

   logic        clock;
   logic        reset_n;
   logic [79:0] ch_address;
   logic [7:0]  ch_byteenable;
   logic [3:0]  ch_read;
   logic [3:0]  ch_write;
   logic [63:0] ch_writedata;
   logic [15:0] ch_readdata;
   logic [3:0]  ch_readdataready;
   logic [3:0]  ch_waitrequest;
   logic [19:0] mem_address;
   logic [1:0]  mem_byteenable;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_writedata;
   logic [15:0] mem_readdata;
   logic        mem_readdataready;
   logic        mem_waitrequest;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;

   logic [19:0] c_addr [4];
   logic [15:0] c_data [4];
   logic [1:0]  c_be   [4];

   typedef struct {
      logic [3:0]  rd;
      logic [3:0]  wr;
      logic        mwait;
      logic        mrdy;
      logic [15:0] mrdata;
      logic        emrd;
      logic        emwr;
      int          ech;
      logic [3:0]  ewait;
      logic [3:0]  erdy;
   } vec_t;

   vec_t vecs[$];

   mem_arb_n #(.NUM_CH(4), .ADDR_WIDTH(20), .DATA_WIDTH(16), .RD_TIMEOUT(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .ch_address(ch_address), .ch_byteenable(ch_byteenable),
      .ch_read(ch_read), .ch_write(ch_write), .ch_writedata(ch_writedata),
      .ch_readdata(ch_readdata), .ch_readdataready(ch_readdataready),
      .ch_waitrequest(ch_waitrequest),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .mem_readdataready(mem_readdataready),
      .mem_waitrequest(mem_waitrequest), .timeout_err(timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] wr, input logic mwait,
                               input logic mrdy, input logic [15:0] mrdata, input logic emrd,
                               input logic emwr, input int ech, input logic [3:0] ewait,
                               input logic [3:0] erdy);
      vec_t v;
      v.rd = rd; v.wr = wr; v.mwait = mwait; v.mrdy = mrdy; v.mrdata = mrdata;
      v.emrd = emrd; v.emwr = emwr; v.ech = ech; v.ewait = ewait; v.erdy = erdy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] rd, input logic [3:0] wr, input logic mwait,
                        input logic mrdy, input logic [15:0] mrdata);
      ch_read           = rd;
      ch_write          = wr;
      mem_waitrequest   = mwait;
      mem_readdataready = mrdy;
      mem_readdata      = mrdata;
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      drive(4'h0, 4'h0, 1'b1, 1'b0, 16'h0000);
      reset_n = 1'b0;
      #1;
      chk("rst_wait", 32'(ch_waitrequest), 32'h0000000F);
      chk("rst_rdy", 32'(ch_readdataready), 32'h00000000);
      chk("rst_mrd_mwr", {30'd0, mem_read, mem_write}, 32'h00000000);
      chk("rst_terr", 32'(timeout_err), 32'h00000000);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      int grants[$];
      int exp_g[5];
      c_addr[0] = 20'h00100; c_addr[1] = 20'h00200; c_addr[2] = 20'h00010; c_addr[3] = 20'h00300;
      c_data[0] = 16'h1111;  c_data[1] = 16'h2222;  c_data[2] = 16'hBEEF;  c_data[3] = 16'h3333;
      c_be[0]   = 2'b11;     c_be[1]   = 2'b11;     c_be[2]   = 2'b11;     c_be[3]   = 2'b01;
      for (int i = 0; i < 4; i++) begin
         ch_address[i*20 +: 20]   = c_addr[i];
         ch_writedata[i*16 +: 16] = c_data[i];
         ch_byteenable[i*2 +: 2]  = c_be[i];
      end
      exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0;
      reset_n = 1'b0;
      drive(4'h0, 4'h0, 1'b1, 1'b0, 16'h0000);

      //                 rd    wr    mw    mrdy  mrdata    emrd  emwr  ch  ewait erdy
      vecs.push_back(mk(4'h0, 4'h0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h0, 4'h4, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h0, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2, 4'hB, 4'h0));
      vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 4'hD, 4'h0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 0, 4'hF, 4'h2));
      vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b1, 16'h7777, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h0, 4'h8, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(4'h0, 4'h8, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 3, 4'hF, 4'h0));
      vecs.push_back(mk(4'h0, 4'h8, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3, 4'h7, 4'h0));
      vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h1, 4'h1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h1, 4'h1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 4'hE, 4'h0));
      vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b1, 16'hA5A5, 1'b0, 1'b0, 0, 4'hF, 4'h1));
      vecs.push_back(mk(4'h0, 4'h2, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h0, 4'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h0, 4'h6, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h0, 4'h6, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 4'hD, 4'h0));
      vecs.push_back(mk(4'h0, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 4'hF, 4'h0));
      vecs.push_back(mk(4'h0, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2, 4'hB, 4'h0));

      #1;
      chk("rst_wait", 32'(ch_waitrequest), 32'h0000000F);
      chk("rst_mrd_mwr", {30'd0, mem_read, mem_write}, 32'h00000000);
      chk("rst_rdy", 32'(ch_readdataready), 32'h00000000);
      chk("rst_terr", 32'(timeout_err), 32'h00000000);
      @(negedge clock);
      reset_n = 1'b1;

      foreach (vecs[n]) begin
         @(negedge clock);
         drive(vecs[n].rd, vecs[n].wr, vecs[n].mwait, vecs[n].mrdy, vecs[n].mrdata);
         #1;
         chk($sformatf("v%0d_mem_read", n), 32'(mem_read), 32'(vecs[n].emrd));
         chk($sformatf("v%0d_mem_write", n), 32'(mem_write), 32'(vecs[n].emwr));
         chk($sformatf("v%0d_waitreq", n), 32'(ch_waitrequest), 32'(vecs[n].ewait));
         chk($sformatf("v%0d_rdready", n), 32'(ch_readdataready), 32'(vecs[n].erdy));
         chk($sformatf("v%0d_rdata", n), 32'(ch_readdata), 32'(vecs[n].mrdata));
         if (vecs[n].emrd || vecs[n].emwr) begin
            chk($sformatf("v%0d_addr", n), 32'(mem_address), 32'(c_addr[vecs[n].ech]));
            chk($sformatf("v%0d_be", n), 32'(mem_byteenable), 32'(c_be[vecs[n].ech]));
            if (vecs[n].emwr)
               chk($sformatf("v%0d_wdata", n), 32'(mem_writedata), 32'(c_data[vecs[n].ech]));
         end
      end

      // All channels reading continuously from reset: grants rotate 0,1,2,3,0.
      pulse_reset();
      drive(4'hF, 4'h0, 1'b0, 1'b1, 16'h0000);
      for (int c = 0; c < 40 && grants.size() < 5; c++) begin
         @(negedge clock);
         #1;
         for (int j = 0; j < 4; j++)
            if (!ch_waitrequest[j]) grants.push_back(j);
      end
      chk("rr_grant_count", 32'(grants.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < grants.size()) chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));

      // Reset during WAIT_RD followed by a stray readdataready.
      pulse_reset();
      drive(4'h1, 4'h0, 1'b0, 1'b0, 16'h0000);
      @(negedge clock);
      #1;
      chk("rst_mid_issue_rd", 32'(mem_read), 32'd1);
      @(negedge clock);
      drive(4'h0, 4'h0, 1'b0, 1'b0, 16'h0000);
      #1;
      chk("rst_mid_waitrd_mrd", 32'(mem_read), 32'd0);
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      @(negedge clock);
      drive(4'h0, 4'h0, 1'b0, 1'b1, 16'h4321);
      #1;
      chk("stray_rdy", 32'(ch_readdataready), 32'h00000000);
      chk("stray_wait", 32'(ch_waitrequest), 32'h0000000F);
      @(negedge clock);
      drive(4'h1, 4'h0, 1'b0, 1'b0, 16'h0000);
      @(negedge clock);
      #1;
      chk("post_rst_grant0_wait", 32'(ch_waitrequest), 32'h0000000E);
      chk("post_rst_grant0_rd", 32'(mem_read), 32'd1);
      @(negedge clock);
      drive(4'h0, 4'h0, 1'b0, 1'b1, 16'h0000);

`ifdef MEM_ARB_RD_TIMEOUT_EN
      begin
         int hit;
         pulse_reset();
         drive(4'h1, 4'h0, 1'b0, 1'b0, 16'h0000);
         @(negedge clock);
         @(negedge clock);
         drive(4'h0, 4'h0, 1'b0, 1'b0, 16'h0000);
         hit = 0;
         for (int n = 1; n <= 40 && hit == 0; n++) begin
            if (n > 1) @(negedge clock);
            #1;
            if (ch_readdataready != 4'h0) begin
               hit = n;
               chk("to_rdy", 32'(ch_readdataready), 32'h00000001);
               chk("to_rdata", 32'(ch_readdata), 32'h0000FFFF);
            end
         end
         chk("to_cycle", 32'(hit), 32'd16);
         @(negedge clock);
         #1;
         chk("to_err", 32'(timeout_err), 32'd1);
      end
`else
      chk("terr_tied", 32'(timeout_err), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
